sync_fifo_flags: RTL and testbench
==================================

// Module: sync_fifo_flags
// PURPOSE
//  Single-clock FIFO with parametrised width and depth, and registered status flags.
//  Flags: full/empty, programmable almost-full/almost-empty, occupancy count.
//  Separate write-overflow and read-underflow error pulses.
//  Buffers streams between producer/consumer stages that share one clock.
// PARAMETERS
//  WIDTH      8               data word width in bits
//  DEPTH      16              number of entries; any value >= 2, need not be a power of two
//  ADDR_WIDTH $clog2(DEPTH)   pointer width (derived)
//  AF_LEVEL   DEPTH-4         almost_full_o asserted when count >= AF_LEVEL; legal range 1..DEPTH
//  AE_LEVEL   2               almost_empty_o asserted when count <= AE_LEVEL; legal range 0..DEPTH-1
// PORTS
//  clk_i           in   1             clock, all logic on posedge
//  rst_i           in   1             synchronous reset, active-high
//  wr_en_i         in   1             write request
//  wdata_i         in   WIDTH         write data
//  rd_en_i         in   1             read request (acknowledge in FWFT mode)
//  rdata_o         out  WIDTH         read data
//  rdata_valid_o   out  1             rdata_o holds a newly read word
//  full_o          out  1             count == DEPTH
//  empty_o         out  1             count == 0
//  almost_full_o   out  1             count >= AF_LEVEL
//  almost_empty_o  out  1             count <= AE_LEVEL
//  count_o         out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
//  wr_err_o        out  1             1-cycle pulse: write attempted while full
//  rd_err_o        out  1             1-cycle pulse: read attempted while empty
// BEHAVIOUR
//  Clock and reset: one clock (clk_i); rst_i is synchronous, active-high.
//  Reset values:
//   - Pointers and wrap toggles = 0.
//   - count_o = 0, empty_o = 1, almost_empty_o = 1, full_o = 0, almost_full_o = 0.
//   - rdata_o = 0, rdata_valid_o = 0, wr_err_o = 0, rd_err_o = 0.
//   - Memory contents are not cleared.
//  Reset mid-operation discards all stored data; the FIFO is empty on the next cycle.
//  Accept rules use registered flags from the start of the cycle:
//   - write accepted = wr_en_i & ~full_o
//   - read accepted  = rd_en_i & ~empty_o
//  Pointers: each advances by 1 on an accepted op; at DEPTH-1 it wraps to 0 and flips its toggle bit.
//  Full/empty decode: pointers equal with equal toggles = empty; pointers equal with differing toggles = full.
//  count_o: +1 on write only, -1 on read only, unchanged on both or neither.
//  All flags are registered and derived from next-state count, so they are valid the cycle after the op.
//  Simultaneous rd+wr:
//   - When full, the read is accepted and the write is rejected (wr_err_o pulses); count becomes DEPTH-1.
//   - When empty, the write is accepted and the read is rejected (rd_err_o pulses); count becomes 1.
//   - Otherwise both are accepted and count is unchanged.
//  Errors: a rejected op leaves state unchanged and pulses its error flag for exactly 1 cycle.
//  Standard read mode:
//   - rdata_o <= mem[rd_ptr] on an accepted read, with 1-cycle latency.
//   - rdata_valid_o = 1 for exactly that following cycle.
//   - rdata_o holds its value otherwise.
// CONFIGURATION
//  SYNC_FIFO_FWFT_EN defined (first-word-fall-through):
//   - rdata_o always presents the head entry, mem[rd_ptr].
//   - rdata_valid_o = ~empty_o.
//   - rd_en_i pops the head; the next word is visible the cycle after the pop.
//   - A word written into an empty FIFO appears on rdata_o one cycle after the write.
//  SYNC_FIFO_FWFT_EN undefined: standard registered read mode, as above.
// TESTING (WIDTH=8, DEPTH=16, AF_LEVEL=12, AE_LEVEL=2)
//  1. Reset, then write 0x01..0x10 (16 words):
//     - full_o=1 and count_o=16 after the last write.
//     - almost_full_o rises the cycle after the 12th write.
//     - A 17th write pulses wr_err_o=1 and the data is dropped.
//  2. Drain 16 words:
//     - rdata_o sequence is 0x01..0x10, each with rdata_valid_o.
//     - almost_empty_o=1 once count_o<=2; empty_o=1 at the end.
//     - An extra read pulses rd_err_o and leaves rdata_o=0x10.
//  3. Wrap-around: perform 40 write/read pairs of an incrementing pattern at occupancy 5.
//     - Data is intact across pointer wrap; count_o stays 5.
//  4. Simultaneous rd+wr:
//     - When full: count goes 16->15 and wr_err_o=1.
//     - When empty: count goes 0->1, rd_err_o=1, rdata_valid_o=0.
//  5. Reset mid-stream: assert rst_i at count_o=7.
//     - Next cycle: count_o=0, empty_o=1.
//     - A subsequent write/read of 0xA5 returns 0xA5.
//  6. With SYNC_FIFO_FWFT_EN: write 0x3C into an empty FIFO.
//     - rdata_o=0x3C and rdata_valid_o=1 one cycle later, with no rd_en_i.
//     - After rd_en_i, rdata_valid_o=0.

Source files
------------

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with registered status flags.
// Provides full/empty, programmable almost-full/almost-empty, occupancy count,
// and one-cycle write-overflow / read-underflow error pulses.
// DEPTH need not be a power of two; pointers wrap explicitly at DEPTH-1 and
// carry a toggle bit so that equal pointers can be told apart as full or empty.
// Optional build macro: SYNC_FIFO_FWFT_EN selects first-word-fall-through
// read mode; when undefined the read port is registered with 1-cycle latency.
module sync_fifo_flags #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int AF_LEVEL   = DEPTH - 4,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  rd_en_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  rdata_valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  wr_err_o,
    output logic                  rd_err_o
);

    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   AF_CNT   = (ADDR_WIDTH + 1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0]   AE_CNT   = (ADDR_WIDTH + 1)'(AE_LEVEL);

    logic [WIDTH-1:0]      r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic                  r_wr_tog;
    logic                  r_rd_tog;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_almost_full;
    logic                  r_almost_empty;
    logic                  r_wr_err;
    logic                  r_rd_err;

    logic [ADDR_WIDTH-1:0] w_wr_ptr_nxt;
    logic [ADDR_WIDTH-1:0] w_rd_ptr_nxt;
    logic                  w_wr_tog_nxt;
    logic                  w_rd_tog_nxt;
    logic [ADDR_WIDTH:0]   w_count_nxt;
    logic                  w_full_nxt;
    logic                  w_empty_nxt;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    // Accept decisions use the flags registered at the start of the cycle, so
    // a simultaneous read on a full FIFO does not free a slot for the write.
    assign w_wr_acc = wr_en_i & ~r_full;
    assign w_rd_acc = rd_en_i & ~r_empty;

    // Next-state pointers, toggles, occupancy and full/empty decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        w_wr_ptr_nxt = r_wr_ptr;
        w_wr_tog_nxt = r_wr_tog;
        w_rd_ptr_nxt = r_rd_ptr;
        w_rd_tog_nxt = r_rd_tog;
        w_count_nxt  = r_count;

        if (w_wr_acc) begin
            if (r_wr_ptr == LAST_PTR) begin
                w_wr_ptr_nxt = '0;
                w_wr_tog_nxt = ~r_wr_tog;
            end else begin
                w_wr_ptr_nxt = r_wr_ptr + 1'b1;
            end
        end

        if (w_rd_acc) begin
            if (r_rd_ptr == LAST_PTR) begin
                w_rd_ptr_nxt = '0;
                w_rd_tog_nxt = ~r_rd_tog;
            end else begin
                w_rd_ptr_nxt = r_rd_ptr + 1'b1;
            end
        end

        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase

        w_empty_nxt = (w_wr_ptr_nxt == w_rd_ptr_nxt) && (w_wr_tog_nxt == w_rd_tog_nxt);
        w_full_nxt  = (w_wr_ptr_nxt == w_rd_ptr_nxt) && (w_wr_tog_nxt != w_rd_tog_nxt);
    end

    // Control state and registered flags, cleared by synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_wr_tog       <= 1'b0;
            r_rd_tog       <= 1'b0;
            r_count        <= '0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_wr_err       <= 1'b0;
            r_rd_err       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_wr_tog       <= w_wr_tog_nxt;
            r_rd_tog       <= w_rd_tog_nxt;
            r_count        <= w_count_nxt;
            r_full         <= w_full_nxt;
            r_empty        <= w_empty_nxt;
            r_almost_full  <= (w_count_nxt >= AF_CNT);
            r_almost_empty <= (w_count_nxt <= AE_CNT);
            r_wr_err       <= wr_en_i & r_full;
            r_rd_err       <= rd_en_i & r_empty;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk_i) begin
        // NOTE: the array has no reset; stale words are unreachable once the pointers clear.
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wdata_i;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head entry is always presented; forced to zero while empty so the idle value is defined.
    assign rdata_o       = r_empty ? '0 : r_mem[r_rd_ptr];
    assign rdata_valid_o = ~r_empty;
`else
    logic [WIDTH-1:0] r_rdata;
    logic             r_rdata_valid;

    // Registered read port: captures the head on an accepted read, holds otherwise.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
        end else begin
            r_rdata_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rdata <= r_mem[r_rd_ptr];
            end
        end
    end

    assign rdata_o       = r_rdata;
    assign rdata_valid_o = r_rdata_valid;
`endif

    assign full_o         = r_full;
    assign empty_o        = r_empty;
    assign almost_full_o  = r_almost_full;
    assign almost_empty_o = r_almost_empty;
    assign count_o        = r_count;
    assign wr_err_o       = r_wr_err;
    assign rd_err_o       = r_rd_err;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed bench for sync_fifo_flags (WIDTH=8, DEPTH=16,
// AF_LEVEL=12, AE_LEVEL=2). Expected read data is queued when a read is
// issued; a monitor pops and compares whenever the DUT presents a word.
// Honours SYNC_FIFO_FWFT_EN to match the DUT build.
module tb_sync_fifo_flags;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wdata;
    logic       rd_en;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic       full;
    logic       empty;
    logic       afull;
    logic       aempty;
    logic [4:0] count;
    logic       wr_err;
    logic       rd_err;

    int         n_checks;
    int         n_fail;
    logic [7:0] sb_q[$];

    sync_fifo_flags #(
        .WIDTH    (8),
        .DEPTH    (16),
        .AF_LEVEL (12),
        .AE_LEVEL (2)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .wr_en_i        (wr_en),
        .wdata_i        (wdata),
        .rd_en_i        (rd_en),
        .rdata_o        (rdata),
        .rdata_valid_o  (rdata_valid),
        .full_o         (full),
        .empty_o        (empty),
        .almost_full_o  (afull),
        .almost_empty_o (aempty),
        .count_o        (count),
        .wr_err_o       (wr_err),
        .rd_err_o       (rd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; returns 1 time unit after the edge.
    task automatic step(input logic wr, input logic [7:0] wd, input logic rd);
        wr_en = wr;
        wdata = wd;
        rd_en = rd;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    // Scoreboard monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
`ifdef SYNC_FIFO_FWFT_EN
        if (!rst && rd_en && rdata_valid) begin
`else
        if (!rst && rdata_valid) begin
`endif
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got data 0x%0h with no expected entry at %0t", rdata, $time);
            end else begin
                check("sb_rdata", rdata, sb_q.pop_front());
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        wdata    = '0;

        // ---- reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_aempty", aempty, 1);
        check("rst_full", full, 0);
        check("rst_afull", afull, 0);
        check("rst_valid", rdata_valid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_wr_err", wr_err, 0);
        check("rst_rd_err", rd_err, 0);

        // ---- 1. fill with 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 8'(i), 1'b0);
            check("fill_count", count, i);
            check("fill_afull", afull, (i >= 12));
            check("fill_full", full, (i == 16));
        end
        step(1'b1, 8'hEE, 1'b0);
        check("ovf_wr_err", wr_err, 1);
        check("ovf_count", count, 16);
        step(1'b0, 8'h00, 1'b0);
        check("ovf_wr_err_clear", wr_err, 0);

        // ---- 2. drain, 0xEE must not appear
        for (int i = 1; i <= 16; i++) begin
            sb_q.push_back(8'(i));
            step(1'b0, 8'h00, 1'b1);
            check("drain_count", count, 16 - i);
            check("drain_aempty", aempty, ((16 - i) <= 2));
            check("drain_empty", empty, (i == 16));
        end
        step(1'b0, 8'h00, 1'b1);
        check("udf_rd_err", rd_err, 1);
        check("udf_valid", rdata_valid, 0);
`ifndef SYNC_FIFO_FWFT_EN
        check("udf_rdata_hold", rdata, 8'h10);
`endif
        step(1'b0, 8'h00, 1'b0);
        check("udf_rd_err_clear", rd_err, 0);

        // ---- 3. wrap-around at occupancy 5
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
        check("wrap_prefill_count", count, 5);
        for (int k = 0; k < 40; k++) begin
            sb_q.push_back(8'(8'h20 + k));
            step(1'b1, 8'(8'h25 + k), 1'b1);
            check("wrap_count", count, 5);
        end
        for (int j = 0; j < 5; j++) begin
            sb_q.push_back(8'(8'h48 + j));
            step(1'b0, 8'h00, 1'b1);
        end
        check("wrap_drained_empty", empty, 1);

        // ---- 4a. simultaneous rd+wr while full
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
        check("sim_full_pre", full, 1);
        sb_q.push_back(8'h60);
        step(1'b1, 8'h99, 1'b1);
        check("sim_full_count", count, 15);
        check("sim_full_wr_err", wr_err, 1);
        check("sim_full_flag", full, 0);
        for (int i = 1; i < 16; i++) begin
            sb_q.push_back(8'(8'h60 + i));
            step(1'b0, 8'h00, 1'b1);
        end
        check("sim_drain_empty", empty, 1);

        // ---- 4b. simultaneous rd+wr while empty
        step(1'b1, 8'h77, 1'b1);
        check("sim_empty_count", count, 1);
        check("sim_empty_rd_err", rd_err, 1);
`ifdef SYNC_FIFO_FWFT_EN
        check("sim_empty_valid", rdata_valid, 1);
`else
        check("sim_empty_valid", rdata_valid, 0);
`endif
        sb_q.push_back(8'h77);
        step(1'b0, 8'h00, 1'b1);
        check("sim_empty_after", count, 0);

        // ---- 5. reset mid-stream at count 7
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
        check("mid_pre_count", count, 7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_count", count, 0);
        check("mid_rst_empty", empty, 1);
        step(1'b1, 8'hA5, 1'b0);
        check("mid_wr_count", count, 1);
        sb_q.push_back(8'hA5);
        step(1'b0, 8'h00, 1'b1);
        check("mid_rd_empty", empty, 1);

`ifdef SYNC_FIFO_FWFT_EN
        // ---- 6. first-word-fall-through
        step(1'b1, 8'h3C, 1'b0);
        check("fwft_rdata", rdata, 8'h3C);
        check("fwft_valid", rdata_valid, 1);
        sb_q.push_back(8'h3C);
        step(1'b0, 8'h00, 1'b1);
        check("fwft_valid_after_pop", rdata_valid, 0);
`endif

        // let the monitor see the last read
        repeat (3) step(1'b0, 8'h00, 1'b0);
        check("sb_drained", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
